// File: rtl/i2c_slave_if.sv
// Application-side handshake between the I2C target and the logic it serves:
// received bytes out, transmit bytes in, plus status for debug.
interface i2c_slave_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic [7:0] tx_data;
   logic       tx_req;
   logic       busy;
   logic [2:0] state;

   modport slave (
      output rx_data, rx_valid, tx_req, busy, state,
      input  tx_data
   );

   modport master (
      input  rx_data, rx_valid, tx_req, busy, state,
      output tx_data
   );
endinterface

// File: rtl/i2c_slave.sv
// I2C target: oversamples sclk/sda on clk, detects START/STOP, matches a 7-bit
// address, receives bytes to rx_data and transmits bytes taken from tx_data.
module i2c_slave #(
   parameter logic [6:0] SLAVE_ADDR  = 7'h77,
   parameter int         SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sclk,
   inout  wire        sda,
   i2c_slave_if.slave app
);
   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      ADDR     = 3'd1,
      ADDR_ACK = 3'd2,
      RX       = 3'd3,
      RX_ACK   = 3'd4,
      TX       = 3'd5,
      TX_ACK   = 3'd6,
      WAIT     = 3'd7
   } state_t;

   logic [SYNC_STAGES-1:0] sclk_sync_reg, sda_sync_reg;
   logic                   sclk_d_reg, sda_d_reg;
   logic                   sclk_s, sda_s;
   logic                   sclk_rise, sclk_fall, sda_rise, sda_fall;
   logic                   start_evt, stop_evt;

   state_t     state_reg, state_next;
   logic [2:0] cnt_reg, cnt_next;
   logic [7:0] shift_reg, shift_next, shift_in;
   logic       byte_done_reg, byte_done_next;
   logic       rw_reg, rw_next;
   logic       sda_low_reg, sda_low_next;
   logic       busy_reg, busy_next;
   logic [7:0] rx_data_reg, rx_data_next;
   logic       rx_valid_reg, rx_valid_next;
   logic       tx_req_reg, tx_req_next;

   // Synchronizers idle high so reset never looks like a bus edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sclk_sync_reg <= '1;
         sda_sync_reg  <= '1;
         sclk_d_reg    <= 1'b1;
         sda_d_reg     <= 1'b1;
      end else begin
         sclk_sync_reg <= {sclk_sync_reg[SYNC_STAGES-2:0], sclk};
         sda_sync_reg  <= {sda_sync_reg[SYNC_STAGES-2:0], sda};
         sclk_d_reg    <= sclk_s;
         sda_d_reg     <= sda_s;
      end
   end

   assign sclk_s    = sclk_sync_reg[SYNC_STAGES-1];
   assign sda_s     = sda_sync_reg[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_d_reg;
   assign sclk_fall = ~sclk_s & sclk_d_reg;
   assign sda_rise  = sda_s & ~sda_d_reg;
   assign sda_fall  = ~sda_s & sda_d_reg;
   // sclk must be steady high in both samples; a coincident sclk edge wins.
   assign start_evt = sda_fall & sclk_s & sclk_d_reg;
   assign stop_evt  = sda_rise & sclk_s & sclk_d_reg;
   assign shift_in  = {shift_reg[6:0], sda_s};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg     <= IDLE;
         cnt_reg       <= 3'd0;
         shift_reg     <= 8'h00;
         byte_done_reg <= 1'b0;
         rw_reg        <= 1'b0;
         sda_low_reg   <= 1'b0;
         busy_reg      <= 1'b0;
         rx_data_reg   <= 8'h00;
         rx_valid_reg  <= 1'b0;
         tx_req_reg    <= 1'b0;
      end else begin
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         shift_reg     <= shift_next;
         byte_done_reg <= byte_done_next;
         rw_reg        <= rw_next;
         sda_low_reg   <= sda_low_next;
         busy_reg      <= busy_next;
         rx_data_reg   <= rx_data_next;
         rx_valid_reg  <= rx_valid_next;
         tx_req_reg    <= tx_req_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      cnt_next       = cnt_reg;
      shift_next     = shift_reg;
      byte_done_next = byte_done_reg;
      rw_next        = rw_reg;
      sda_low_next   = sda_low_reg;
      busy_next      = busy_reg;
      rx_data_next   = rx_data_reg;
      rx_valid_next  = 1'b0;
      tx_req_next    = 1'b0;

      if (stop_evt) begin
         state_next     = IDLE;
         cnt_next       = 3'd0;
         byte_done_next = 1'b0;
         sda_low_next   = 1'b0;
         busy_next      = 1'b0;
      end else if (start_evt) begin
         state_next     = ADDR;
         cnt_next       = 3'd0;
         byte_done_next = 1'b0;
         sda_low_next   = 1'b0;
      end else begin
         unique case (state_reg)
            ADDR: begin
               if (sclk_rise) begin
                  shift_next = shift_in;
                  cnt_next   = cnt_reg + 3'd1;
                  if (cnt_reg == 3'd7) byte_done_next = 1'b1;
               end else if (sclk_fall && byte_done_reg) begin
                  byte_done_next = 1'b0;
                  if (shift_reg[7:1] == SLAVE_ADDR) begin
                     state_next   = ADDR_ACK;
                     sda_low_next = 1'b1;
                     busy_next    = 1'b1;
                     rw_next      = shift_reg[0];
                     tx_req_next  = shift_reg[0];
                  end else begin
                     state_next = WAIT;
                  end
               end
            end
            ADDR_ACK: begin
               if (sclk_fall) begin
                  cnt_next       = 3'd0;
                  byte_done_next = 1'b0;
                  if (rw_reg) begin
                     state_next   = TX;
                     shift_next   = app.tx_data;
                     sda_low_next = ~app.tx_data[7];
                  end else begin
                     state_next   = RX;
                     sda_low_next = 1'b0;
                  end
               end
            end
            RX: begin
               if (sclk_rise) begin
                  shift_next = shift_in;
                  cnt_next   = cnt_reg + 3'd1;
                  if (cnt_reg == 3'd7) begin
                     rx_data_next   = shift_in;
                     rx_valid_next  = 1'b1;
                     byte_done_next = 1'b1;
                  end
               end else if (sclk_fall && byte_done_reg) begin
                  state_next     = RX_ACK;
                  sda_low_next   = 1'b1;
                  byte_done_next = 1'b0;
               end
            end
            RX_ACK: begin
               if (sclk_fall) begin
                  state_next   = RX;
                  sda_low_next = 1'b0;
               end
            end
            TX: begin
               if (sclk_rise) begin
                  cnt_next = cnt_reg + 3'd1;
                  if (cnt_reg == 3'd7) byte_done_next = 1'b1;
               end else if (sclk_fall) begin
                  if (byte_done_reg) begin
                     state_next     = TX_ACK;
                     sda_low_next   = 1'b0;
                     byte_done_next = 1'b0;
                  end else begin
                     shift_next   = {shift_reg[6:0], 1'b0};
                     sda_low_next = ~shift_reg[6];
                  end
               end
            end
            TX_ACK: begin
               // byte_done doubles as "master ACKed, reload on next fall".
               if (sclk_rise) begin
                  if (!sda_s) begin
                     tx_req_next    = 1'b1;
                     byte_done_next = 1'b1;
                  end else begin
                     state_next = WAIT;
                  end
               end else if (sclk_fall && byte_done_reg) begin
                  state_next     = TX;
                  byte_done_next = 1'b0;
                  shift_next     = app.tx_data;
                  sda_low_next   = ~app.tx_data[7];
               end
            end
            default: ;
         endcase
      end
   end

   // Gated by rst so the line lets go the instant reset asserts.
   assign sda = (rst && sda_low_reg) ? 1'b0 : 1'bz;

   assign app.rx_data  = rx_data_reg;
   assign app.rx_valid = rx_valid_reg;
   assign app.tx_req   = tx_req_reg;
   assign app.busy     = busy_reg;
   assign app.state    = state_reg;
endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: bit-banged open-drain master, transaction-level expectations
// (address hit, byte queues) and randomized write/read transfers.
module tb_i2c_slave;
   localparam int         HP   = 8;
   localparam logic [6:0] ADDR = 7'h77;

   logic clk   = 1'b0;
   logic rst   = 1'b0;
   logic sclk  = 1'b1;
   logic m_low = 1'b0;
   wire  sda;

   pullup (sda);
   assign sda = m_low ? 1'b0 : 1'bz;

   i2c_slave_if app_if ();

   i2c_slave #(.SLAVE_ADDR(ADDR), .SYNC_STAGES(2)) dut (
      .clk  (clk),
      .rst  (rst),
      .sclk (sclk),
      .sda  (sda),
      .app  (app_if)
   );

   always #5 clk = ~clk;

   int err_cnt = 0;
   int chk_cnt = 0;

   logic [7:0] rx_got[$];
   logic [7:0] tx_src[$];
   logic [7:0] wr_q[$];
   logic [7:0] rd_q[$];
   int         tx_req_cnt    = 0;
   int         slave_drv_cnt = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic bit addr_hit(input logic [7:0] ab);
      return ab[7:1] == ADDR;
   endfunction

   // Application side: capture received bytes, answer tx_req from tx_src.
   always @(negedge clk) begin
      if (!rst) app_if.tx_data = 8'h00;
      if (app_if.rx_valid) rx_got.push_back(app_if.rx_data);
      if (app_if.tx_req) begin
         tx_req_cnt++;
         if (tx_src.size() > 0) app_if.tx_data = tx_src.pop_front();
      end
      if (!m_low && sda === 1'b0) slave_drv_cnt++;
   end

   task automatic wait_clks(input int n);
      repeat (n) @(posedge clk);
   endtask

   task automatic bus_start();
      m_low = 1'b0; wait_clks(HP);
      sclk  = 1'b1; wait_clks(HP);
      m_low = 1'b1; wait_clks(HP);
      sclk  = 1'b0; wait_clks(2);
   endtask

   task automatic bus_stop();
      m_low = 1'b1; wait_clks(HP);
      sclk  = 1'b1; wait_clks(HP);
      m_low = 1'b0; wait_clks(HP);
   endtask

   task automatic put_bit(input logic b);
      m_low = ~b;   wait_clks(HP);
      sclk  = 1'b1; wait_clks(HP);
      sclk  = 1'b0; wait_clks(2);
   endtask

   task automatic get_bit(output logic b);
      m_low = 1'b0; wait_clks(HP);
      sclk  = 1'b1; wait_clks(HP / 2);
      b = (sda !== 1'b0);
      wait_clks(HP - HP / 2);
      sclk  = 1'b0; wait_clks(2);
   endtask

   task automatic put_byte(input logic [7:0] d, output logic ack);
      for (int i = 7; i >= 0; i--) put_bit(d[i]);
      get_bit(ack);
   endtask

   task automatic get_byte(input logic nack, output logic [7:0] d);
      logic b;
      for (int i = 7; i >= 0; i--) begin
         get_bit(b);
         d[i] = b;
      end
      put_bit(nack);
   endtask

   task automatic xfer_write(input logic [7:0] ab);
      logic ack;
      bit   hit;
      hit = addr_hit(ab);
      rx_got.delete();
      slave_drv_cnt = 0;
      bus_start();
      put_byte(ab, ack);
      check_eq("wr_addr_ack", ack, hit ? 1'b0 : 1'b1);
      @(negedge clk);
      check_eq("wr_busy_after_addr", app_if.busy, hit);
      if (!hit) check_eq("wr_state_wait", app_if.state, 3'd7);
      foreach (wr_q[i]) begin
         put_byte(wr_q[i], ack);
         check_eq("wr_data_ack", ack, hit ? 1'b0 : 1'b1);
      end
      if (!hit) check_eq("wr_no_drive", slave_drv_cnt, 0);
      bus_stop();
      wait_clks(4);
      @(negedge clk);
      check_eq("wr_busy_after_stop", app_if.busy, 1'b0);
      check_eq("wr_state_idle", app_if.state, 3'd0);
      check_eq("wr_rx_count", rx_got.size(), hit ? wr_q.size() : 0);
      if (hit) begin
         for (int i = 0; i < wr_q.size(); i++)
            if (i < rx_got.size()) check_eq("wr_rx_data", rx_got[i], wr_q[i]);
      end
   endtask

   task automatic xfer_read(input logic [7:0] ab);
      logic       ack;
      logic [7:0] d;
      bit         hit;
      int         req0;
      hit    = addr_hit(ab);
      tx_src = rd_q;
      req0   = tx_req_cnt;
      slave_drv_cnt = 0;
      bus_start();
      put_byte(ab, ack);
      check_eq("rd_addr_ack", ack, hit ? 1'b0 : 1'b1);
      if (hit) begin
         for (int i = 0; i < rd_q.size(); i++) begin
            get_byte(i == rd_q.size() - 1, d);
            check_eq("rd_data", d, rd_q[i]);
         end
      end else begin
         check_eq("rd_no_drive", slave_drv_cnt, 0);
      end
      wait_clks(4);
      @(negedge clk);
      check_eq("rd_state_wait", app_if.state, 3'd7);
      check_eq("rd_tx_req_count", tx_req_cnt - req0, hit ? rd_q.size() : 0);
      bus_stop();
      wait_clks(4);
      @(negedge clk);
      check_eq("rd_state_idle", app_if.state, 3'd0);
      check_eq("rd_busy_after_stop", app_if.busy, 1'b0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic       ack;
      logic [7:0] d;
      logic [6:0] a7;
      int         req0;

      wait_clks(3);
      @(negedge clk);
      check_eq("rst_state", app_if.state, 3'd0);
      check_eq("rst_busy", app_if.busy, 1'b0);
      check_eq("rst_rx_valid", app_if.rx_valid, 1'b0);
      check_eq("rst_tx_req", app_if.tx_req, 1'b0);
      check_eq("rst_rx_data", app_if.rx_data, 8'h00);
      check_eq("rst_sda_released", sda !== 1'b0, 1'b1);
      rst = 1'b1;
      wait_clks(4);

      // Directed write: two data bytes.
      wr_q = {8'hA5, 8'h3C};
      xfer_write(8'hEE);
      $display("write EE A5 3C -> rx_got=%0d bytes", rx_got.size());

      // Wrong address.
      wr_q.delete();
      xfer_write(8'h42);
      $display("write 42 (no match)");

      // Directed read: ACK first byte, NACK second.
      rd_q = {8'h96, 8'h0F};
      xfer_read(8'hEF);
      $display("read EF -> 96 0F");

      // Repeated START between a write and a read.
      rx_got.delete();
      tx_src = {8'h5A};
      req0   = tx_req_cnt;
      bus_start();
      put_byte(8'hEE, ack);
      check_eq("rs_addr_ack", ack, 1'b0);
      put_byte(8'h11, ack);
      check_eq("rs_data_ack", ack, 1'b0);
      bus_start();
      put_byte(8'hEF, ack);
      check_eq("rs_raddr_ack", ack, 1'b0);
      get_byte(1'b1, d);
      check_eq("rs_read_data", d, 8'h5A);
      bus_stop();
      wait_clks(4);
      @(negedge clk);
      check_eq("rs_rx_count", rx_got.size(), 1);
      check_eq("rs_rx_data", app_if.rx_data, 8'h11);
      check_eq("rs_tx_req_count", tx_req_cnt - req0, 1);
      check_eq("rs_state_idle", app_if.state, 3'd0);
      $display("repeated start EE 11 / EF -> %0h", d);

      // Abort mid-byte with STOP.
      rx_got.delete();
      bus_start();
      put_byte(8'hEE, ack);
      check_eq("ab_addr_ack", ack, 1'b0);
      for (int i = 0; i < 4; i++) put_bit(1'($urandom_range(0, 1)));
      bus_stop();
      wait_clks(4);
      @(negedge clk);
      check_eq("ab_rx_count", rx_got.size(), 0);
      check_eq("ab_state_idle", app_if.state, 3'd0);
      check_eq("ab_sda_released", sda !== 1'b0, 1'b1);
      $display("abort after 4 bits");

      // Reset while the target holds the address ACK.
      bus_start();
      for (int i = 7; i >= 0; i--) put_bit(d[i] ^ d[i] ^ (8'hEE >> i) & 1'b1);
      wait_clks(3);
      #1;
      check_eq("rr_ack_held", sda, 1'b0);
      check_eq("rr_state_addr_ack", app_if.state, 3'd2);
      rst   = 1'b0;
      m_low = 1'b0;
      #1;
      check_eq("rr_sda_released", sda !== 1'b0, 1'b1);
      check_eq("rr_state", app_if.state, 3'd0);
      check_eq("rr_busy", app_if.busy, 1'b0);
      check_eq("rr_rx_data", app_if.rx_data, 8'h00);
      wait_clks(4);
      rst = 1'b1;
      wait_clks(4);
      put_byte(8'hEE, ack);
      check_eq("rr_no_resp_before_start", ack, 1'b1);
      wr_q = {8'($urandom), 8'($urandom)};
      xfer_write(8'hEE);
      $display("reset during ADDR_ACK, then write ok");

      // Randomized transfers.
      for (int t = 0; t < 8; t++) begin
         bit is_read;
         bit hit;
         int n;
         is_read = 1'($urandom_range(0, 1));
         hit     = ($urandom_range(0, 3) != 0);
         if (hit) a7 = ADDR;
         else begin
            do a7 = 7'($urandom_range(0, 127)); while (a7 == ADDR);
         end
         n = $urandom_range(1, 3);
         if (is_read) begin
            rd_q.delete();
            for (int i = 0; i < n; i++) rd_q.push_back(8'($urandom));
            xfer_read({a7, 1'b1});
         end else begin
            wr_q.delete();
            for (int i = 0; i < n; i++) wr_q.push_back(8'($urandom));
            xfer_write({a7, 1'b0});
         end
         $display("random %0d: %s addr=%0h bytes=%0d", t, is_read ? "read" : "write", a7, n);
      end

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end
endmodule
